// File: rtl/imem_loader_pkg.sv
// Shared constants and helpers for the instruction-memory loader: state
// encodings, frame header byte, memory depth and frame-field checks.
package imem_loader_pkg;

  localparam logic [2:0] LDR_IDLE  = 3'd0;
  localparam logic [2:0] LDR_COUNT = 3'd1;
  localparam logic [2:0] LDR_DATA  = 3'd2;
  localparam logic [2:0] LDR_CSUM  = 3'd3;
  localparam logic [2:0] LDR_DONE  = 3'd4;
  localparam logic [2:0] LDR_ERR   = 3'd5;

  localparam logic [7:0] LDR_HDR    = 8'hA5;
  localparam int         IMEM_DEPTH = 16;

  // A count field is usable only if it names 1..IMEM_DEPTH instructions.
  function automatic logic count_ok(input logic [7:0] n);
    return (n != 8'd0) && (n <= 8'(IMEM_DEPTH));
  endfunction

  function automatic logic csum_ok(input logic [7:0] sum, input logic [7:0] c);
    logic [7:0] total;
    total = sum + c;
    return total == 8'd0;
  endfunction

endpackage

// File: rtl/ldr_timeout.sv
// Saturating idle-cycle counter; expired flags the idle cycle that completes
// TIMEOUT_CYCLES consecutive cycles without a clear.
module ldr_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_r;

  // Idle counter: cleared on activity, holds once the limit is reached.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable & (count_r == LAST);

endmodule

// File: rtl/imem_loader.sv
// Framed program loader: writes instruction bytes to sequential addresses,
// verifies the checksum and releases the core only after a clean frame.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  core_run,
  output logic                  load_err
);

  logic [2:0]            state_r;
  logic [2:0]            next_state_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH-1:0] last_addr_r;
  logic [DATA_WIDTH-1:0] sum_r;
  logic                  ready_s;
  logic                  in_frame_s;
  logic                  xfer_s;
  logic                  tmo_clear_s;
  logic                  tmo_enable_s;
  logic                  expired_s;

  // Ready and in-frame decode from state only, never from in_valid.
  always_comb begin
    ready_s    = 1'b0;
    in_frame_s = 1'b0;
    case (state_r)
      LDR_IDLE, LDR_ERR:              ready_s = 1'b1;
      LDR_COUNT, LDR_DATA, LDR_CSUM: begin
        ready_s    = 1'b1;
        in_frame_s = 1'b1;
      end
      default: begin
        ready_s    = 1'b0;
        in_frame_s = 1'b0;
      end
    endcase
  end

  assign in_ready     = ready_s & sys_rst;
  assign xfer_s       = in_valid & in_ready;
  assign tmo_clear_s  = xfer_s | ~in_frame_s;
  assign tmo_enable_s = in_frame_s & ~xfer_s;

  ldr_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (sys_clk),
    .rst_n  (sys_rst),
    .clear  (tmo_clear_s),
    .enable (tmo_enable_s),
    .expired(expired_s)
  );

  // Frame sequencing; a transfer always wins over a simultaneous timeout.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      LDR_IDLE, LDR_ERR: begin
        if (xfer_s && (8'(in_data) == LDR_HDR)) next_state_s = LDR_COUNT;
        else                                     next_state_s = state_r;
      end
      LDR_COUNT: begin
        if (xfer_s)         next_state_s = count_ok(8'(in_data)) ? LDR_DATA : LDR_ERR;
        else if (expired_s) next_state_s = LDR_ERR;
        else                next_state_s = state_r;
      end
      LDR_DATA: begin
        if (xfer_s && (addr_r == last_addr_r)) next_state_s = LDR_CSUM;
        else if (!xfer_s && expired_s)         next_state_s = LDR_ERR;
        else                                   next_state_s = state_r;
      end
      LDR_CSUM: begin
        if (xfer_s)         next_state_s = csum_ok(8'(sum_r), 8'(in_data)) ? LDR_DONE : LDR_ERR;
        else if (expired_s) next_state_s = LDR_ERR;
        else                next_state_s = state_r;
      end
      LDR_DONE: begin
        if (reload) next_state_s = LDR_IDLE;
        else        next_state_s = state_r;
      end
      default: next_state_s = LDR_IDLE;
    endcase
  end

  // State, address/sum counters and registered memory-port and status outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_r     <= LDR_IDLE;
      addr_r      <= '0;
      last_addr_r <= '0;
      sum_r       <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      core_run    <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      core_run <= (next_state_s == LDR_DONE);
      load_err <= (next_state_s == LDR_ERR);
      imem_we  <= 1'b0;
      if (xfer_s && (state_r == LDR_COUNT)) begin
        addr_r      <= '0;
        sum_r       <= '0;
        // A count of IMEM_DEPTH wraps to all-ones here, i.e. the top address.
        last_addr_r <= in_data[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
      end else if (xfer_s && (state_r == LDR_DATA)) begin
        imem_we    <= 1'b1;
        imem_addr  <= addr_r;
        imem_wdata <= in_data;
        addr_r     <= addr_r + ADDR_WIDTH'(1);
        sum_r      <= sum_r + in_data;
      end else begin
        addr_r <= addr_r;
        sum_r  <= sum_r;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame-level bench for imem_loader: expected writes and status
// come from the frame rules applied to each generated frame.
module tb_imem_loader;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       reload = 1'b0;
  logic       imem_we;
  logic [3:0] imem_addr;
  logic [7:0] imem_wdata;
  logic       core_run;
  logic       load_err;

  imem_loader #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .reload    (reload),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_run  (core_run),
    .load_err  (load_err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];

  // Capture every write strobe with the edge number that produced it.
  always @(negedge sys_clk) begin
    if (imem_we === 1'b1) obs_q.push_back('{cyc, imem_addr, imem_wdata});
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, output int xc);
    bit rdy;
    int waits;
    waits    = 0;
    in_data  = b;
    in_valid = 1'b1;
    forever begin
      rdy = in_ready;
      @(negedge sys_clk);
      if (rdy) break;
      waits++;
      if (waits > 300) begin
        check("ready_wait", 32'd0, 32'd1);
        break;
      end
    end
    xc = cyc;
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic check_writes(input string tag);
    int n;
    #1;
    check({tag, "_wr_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_wr_addr"}, obs_q[i].a, exp_q[i].a);
      check({tag, "_wr_data"}, obs_q[i].d, exp_q[i].d);
      check({tag, "_wr_cycle"}, obs_q[i].c, exp_q[i].c);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_frame(input string tag, input logic [7:0] n, input logic [7:0] dat [16],
                           input logic [7:0] c, input int max_gap, output bit good);
    int         xc;
    logic [7:0] sum;
    logic [7:0] total;
    sum = 8'h00;
    send_byte(8'hA5, xc);
    gap($urandom_range(max_gap, 0));
    send_byte(n, xc);
    if (n < 8'd1 || n > 8'd16) begin
      good = 1'b0;
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        gap($urandom_range(max_gap, 0));
        send_byte(dat[i], xc);
        exp_q.push_back('{xc, 4'(i), dat[i]});
        sum = sum + dat[i];
      end
      gap($urandom_range(max_gap, 0));
      send_byte(c, xc);
      total = sum + c;
      good  = (total == 8'h00);
    end
    in_valid = 1'b0;
    check({tag, "_core_run"}, core_run, good);
    check({tag, "_load_err"}, load_err, !good);
    check({tag, "_in_ready"}, in_ready, !good);
    check_writes(tag);
  endtask

  // Leave DONE with a header byte offered in the same cycle; it must be refused.
  task automatic do_reload(input string tag);
    @(negedge sys_clk);
    reload   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge sys_clk);
    reload   = 1'b0;
    in_valid = 1'b0;
    check({tag, "_reload_core_run"}, core_run, 1'b0);
    check({tag, "_reload_in_ready"}, in_ready, 1'b1);
    check({tag, "_reload_load_err"}, load_err, 1'b0);
  endtask

  logic [7:0] d [16];
  bit         good;
  int         xc;

  initial begin
    repeat (3) @(negedge sys_clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_imem_we", imem_we, 1'b0);
    check("rst_imem_addr", imem_addr, 4'h0);
    check("rst_imem_wdata", imem_wdata, 8'h00);
    check("rst_core_run", core_run, 1'b0);
    check("rst_load_err", load_err, 1'b0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("idle_in_ready", in_ready, 1'b1);
    reload = 1'b1;
    @(negedge sys_clk);
    reload = 1'b0;
    check("idle_reload_core_run", core_run, 1'b0);
    check("idle_reload_in_ready", in_ready, 1'b1);

    // Good load 11,22,33: the checksum closing the sum to zero mod 256 is 9A.
    d = '{default: 8'h00};
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    run_frame("good3", 8'd3, d, 8'h9A, 0, good);
    check("good3_flag", good, 1'b1);
    do_reload("good3");

    // Same data closed with CB leaves a residue of 31, so it must fail.
    run_frame("cb3", 8'd3, d, 8'hCB, 0, good);

    d[0] = 8'h01; d[1] = 8'h02;
    run_frame("badcsum", 8'd2, d, 8'h00, 0, good);
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    run_frame("recover", 8'd3, d, 8'h9A, 1, good);
    do_reload("recover");

    run_frame("cnt00", 8'h00, d, 8'h00, 0, good);
    run_frame("cnt11", 8'h11, d, 8'h00, 0, good);

    for (int i = 0; i < 16; i++) d[i] = 8'(i);
    run_frame("full16", 8'd16, d, 8'h88, 0, good);
    do_reload("full16");

    // Timeout: exactly 255 idle cycles inside a frame forces the error state.
    send_byte(8'hA5, xc);
    send_byte(8'h02, xc);
    send_byte(8'h44, xc);
    exp_q.push_back('{xc, 4'h0, 8'h44});
    gap(254);
    check("tmo_254_load_err", load_err, 1'b0);
    gap(1);
    check("tmo_255_load_err", load_err, 1'b1);
    check("tmo_core_run", core_run, 1'b0);
    check_writes("tmo");

    // Reset in the middle of the data phase.
    send_byte(8'hA5, xc);
    send_byte(8'h04, xc);
    send_byte(8'h01, xc);
    exp_q.push_back('{xc, 4'h0, 8'h01});
    send_byte(8'h02, xc);
    exp_q.push_back('{xc, 4'h1, 8'h02});
    in_data = 8'h03;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("mrst_imem_we", imem_we, 1'b0);
    check("mrst_imem_addr", imem_addr, 4'h0);
    check("mrst_imem_wdata", imem_wdata, 8'h00);
    check("mrst_core_run", core_run, 1'b0);
    check("mrst_load_err", load_err, 1'b0);
    check("mrst_in_ready", in_ready, 1'b0);
    repeat (2) @(negedge sys_clk);
    in_valid = 1'b0;
    sys_rst  = 1'b1;
    gap(3);
    check_writes("mrst");
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    run_frame("postrst", 8'd3, d, 8'h9A, 0, good);
    do_reload("postrst");

    // Randomized frames with junk between frames and short gaps inside them.
    for (int f = 0; f < 30; f++) begin
      int         r;
      int         nj;
      logic [7:0] n;
      logic [7:0] s;
      logic [7:0] b;
      logic [7:0] c;
      nj = $urandom_range(2, 0);
      for (int j = 0; j < nj; j++) begin
        b = 8'($urandom_range(255, 0));
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b, xc);
      end
      r = $urandom_range(9, 0);
      if (r == 0)      n = 8'h00;
      else if (r == 1) n = 8'($urandom_range(255, 17));
      else             n = 8'($urandom_range(16, 1));
      s = 8'h00;
      for (int i = 0; i < 16; i++) begin
        d[i] = 8'($urandom_range(255, 0));
        if (i < int'(n)) s = s + d[i];
      end
      c = 8'h00 - s;
      if ($urandom_range(3, 0) == 0) c = c + 8'($urandom_range(255, 1));
      run_frame("rand", n, d, c, 3, good);
      if (good) do_reload("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
